// File: rtl/i2c_pkg.sv
// i2c_pkg: encodings shared between the I2C master and target, plus the target FSM states.
package i2c_pkg;
    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADR, ST_ACK_DEV, ST_REG_ADR, ST_ACK_REG,
        ST_WDATA, ST_ACK_WR, ST_RDATA, ST_MACK, ST_IGNORE
    } i2c_tgt_state_t;
    localparam logic I2C_RW_READ = 1'b1;
    localparam logic I2C_ACK     = 1'b0;
endpackage

// File: rtl/i2c_pin_filter.sv
// i2c_pin_filter: 2-FF synchroniser followed by a stability filter; the output
// only follows the pin after it has held a new level for FILT_LEN cycles.
module i2c_pin_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);
    logic [1:0] sync;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt  <= '0;
            dout <= 1'b1;
        end else begin
            sync <= {sync[0], din};
            if (sync[1] == dout) begin
                cnt <= '0;
            end else if (cnt == 4'(FILT_LEN - 1)) begin
                dout <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target bridging bus transfers onto a local register
// port, with auto-incrementing register pointer and NACK on miss/out-of-range.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADR   = 7'h10,
    parameter int         NUM_REGS  = 16,
    parameter int         REG_ADR_W = 8,
    parameter int         FILT_LEN  = 3
) (
    input  logic                 clk_ip,
    input  logic                 rst_n_ip,
    input  logic                 scl_ip,
    input  logic                 sda_ip,
    output logic                 sda_oe_op,
    output logic                 reg_wr_op,
    output logic [REG_ADR_W-1:0] reg_adr_op,
    output logic [7:0]           reg_wdata_op,
    output logic                 reg_rd_op,
    input  logic [7:0]           reg_rdata_ip,
    output logic                 busy_op
);
    i2c_tgt_state_t state, nxt;
    logic scl_f, sda_f, scl_q, sda_q;
    logic scl_rise, scl_fall, start, stop, byte_done, shift_st;
    logic [3:0] bit_cnt;
    logic [7:0] sh, tx;
    logic [REG_ADR_W-1:0] ptr, ptr_inc;

    i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_scl (.clk(clk_ip), .rst_n(rst_n_ip), .din(scl_ip), .dout(scl_f));
    i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_sda (.clk(clk_ip), .rst_n(rst_n_ip), .din(sda_ip), .dout(sda_f));

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start     = scl_f & scl_q & sda_q & ~sda_f;
    assign stop      = scl_f & scl_q & ~sda_q & sda_f;
    assign byte_done = bit_cnt == 4'd8;
    assign shift_st  = state inside {ST_DEV_ADR, ST_REG_ADR, ST_WDATA, ST_RDATA, ST_MACK};
    assign ptr_inc   = (ptr == REG_ADR_W'(NUM_REGS - 1)) ? '0 : ptr + REG_ADR_W'(1);

    always_ff @(posedge clk_ip or negedge rst_n_ip) begin
        if (!rst_n_ip) begin
            state <= ST_IDLE;
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            state <= nxt;
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    // State moves on SCL falls so ACK/data drive always lines up with the low phase.
    always_comb begin
        nxt = state;
        if (start) begin
            nxt = ST_DEV_ADR;
        end else if (stop) begin
            nxt = ST_IDLE;
        end else if (scl_fall) begin
            case (state)
                ST_DEV_ADR: if (byte_done) nxt = (sh[7:1] == DEV_ADR) ? ST_ACK_DEV : ST_IDLE;
                ST_ACK_DEV: nxt = (sh[0] == I2C_RW_READ) ? ST_RDATA : ST_REG_ADR;
                ST_REG_ADR: if (byte_done) nxt = ({1'b0, sh} < 9'(NUM_REGS)) ? ST_ACK_REG : ST_IGNORE;
                ST_ACK_REG: nxt = ST_WDATA;
                ST_WDATA:   if (byte_done) nxt = ST_ACK_WR;
                ST_ACK_WR:  nxt = ST_WDATA;
                ST_RDATA:   if (byte_done) nxt = ST_MACK;
                ST_MACK:    nxt = (sh[0] == I2C_ACK) ? ST_RDATA : ST_IGNORE;
                default:    nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_ip or negedge rst_n_ip) begin
        if (!rst_n_ip) begin
            bit_cnt      <= '0;
            sh           <= '0;
            tx           <= '0;
            ptr          <= '0;
            sda_oe_op    <= 1'b0;
            reg_wr_op    <= 1'b0;
            reg_rd_op    <= 1'b0;
            reg_adr_op   <= '0;
            reg_wdata_op <= '0;
            busy_op      <= 1'b0;
        end else begin
            reg_wr_op <= 1'b0;
            reg_rd_op <= 1'b0;
            if (start || stop) begin
                bit_cnt   <= '0;
                sda_oe_op <= 1'b0;
                if (stop) busy_op <= 1'b0;
            end else if (scl_rise && shift_st) begin
                sh      <= {sh[6:0], sda_f};
                bit_cnt <= bit_cnt + 4'd1;
                if (state == ST_WDATA && bit_cnt == 4'd7) begin
                    reg_wr_op    <= 1'b1;
                    reg_wdata_op <= {sh[6:0], sda_f};
                    reg_adr_op   <= ptr;
                    ptr          <= ptr_inc;
                end
            end else if (scl_fall) begin
                case (state)
                    ST_DEV_ADR: if (nxt == ST_ACK_DEV) begin
                        sda_oe_op <= 1'b1;
                        busy_op   <= 1'b1;
                    end
                    ST_REG_ADR: if (nxt == ST_ACK_REG) begin
                        sda_oe_op <= 1'b1;
                        ptr       <= REG_ADR_W'(sh);
                    end
                    ST_WDATA: if (byte_done) sda_oe_op <= 1'b1;
                    ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR, ST_MACK: begin
                        bit_cnt <= '0;
                        if (nxt == ST_RDATA) begin
                            reg_rd_op  <= 1'b1;
                            reg_adr_op <= ptr;
                        end else begin
                            sda_oe_op <= 1'b0;
                        end
                    end
                    ST_RDATA: if (byte_done) begin
                        sda_oe_op <= 1'b0;
                        ptr       <= ptr_inc;
                        bit_cnt   <= '0;
                    end else begin
                        tx        <= {tx[6:0], 1'b0};
                        sda_oe_op <= ~tx[6];
                    end
                    default: ;
                endcase
            end else if (reg_rd_op) begin
                // Read data arrives the cycle after the strobe; MSB goes straight onto the bus.
                tx        <= reg_rdata_ip;
                sda_oe_op <= ~reg_rdata_ip[7];
            end
        end
    end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesisable I2C target (slave) with an 8-bit register-file port, the successor to the behavioural slave model in our I2C master bench. Adds read transfers, a parametrised device address and register count, glitch filtering of the bus, auto-increment with wrap-around, and NACK on address miss or out-of-range register. Sits between the board I2C pins (via an open-drain pad) and a local register bank, all in the system clock domain. The block never stretches SCL.

## Interface
- `DEV_ADR`, 7'h10: 7-bit device address.
- `NUM_REGS`, 16: number of registers, 2..256.
- `REG_ADR_W`, 8: width of `reg_adr_op`; must satisfy 2^REG_ADR_W >= NUM_REGS.
- `FILT_LEN`, 3: cycles a synchronised pin must be stable before its filtered value changes, 1..15.

Ports:
- `clk_ip` in 1: system clock (100 MHz nominal).
- `rst_n_ip` in 1: asynchronous, active-low reset.
- `scl_ip` in 1: SCL pin input.
- `sda_ip` in 1: SDA pin input.
- `sda_oe_op` out 1: 1 pulls SDA low; 0 releases it.
- `reg_wr_op` out 1: one-cycle write strobe.
- `reg_adr_op` out REG_ADR_W: register address; valid with `reg_wr_op` or `reg_rd_op`.
- `reg_wdata_op` out 8: write data; valid with `reg_wr_op`.
- `reg_rd_op` out 1: one-cycle read strobe.
- `reg_rdata_ip` in 8: read data, sampled on the cycle after `reg_rd_op`.
- `busy_op` out 1: high from the START that addressed this device until STOP.

## Operation
- Input path: 2-FF synchroniser, then a stability filter of FILT_LEN cycles, producing filtered `scl_f`/`sda_f`. Edge detects run on the filtered values.
- START: `sda_f` falls while `scl_f` is high. STOP: `sda_f` rises while `scl_f` is high. A START seen in any state is a repeated START and enters DEV_ADR. A STOP seen in any state goes to IDLE, releases SDA, and clears `busy_op`.
- Sampling: SDA is sampled on the `scl_f` rising edge. `sda_oe_op` changes only on the `scl_f` falling edge. Bytes are MSB first.
- States:
  - IDLE
  - DEV_ADR: after 8 bits, go to ACK_DEV if bits[7:1]==DEV_ADR; otherwise go to IDLE with SDA released.
  - ACK_DEV: goes to REG_ADR if R/W=0, or RDATA if R/W=1.
  - REG_ADR: after 8 bits, go to ACK_REG if value < NUM_REGS; otherwise go to IGNORE (NACK) and leave the pointer unchanged.
  - ACK_REG: goes to WDATA.
  - WDATA: after 8 bits, pulse `reg_wr_op` and go to ACK_WR.
  - ACK_WR: goes to WDATA.
  - RDATA: after 8 bits, go to MACK.
  - MACK: master ACK goes to RDATA; master NACK goes to IGNORE.
  - IGNORE: waits for START or STOP.
- Register pointer: loaded in ACK_REG and incremented after every written or read byte. It wraps from NUM_REGS-1 to 0. The pointer persists across transfers until reset.
- Read: entering RDATA pulses `reg_rd_op` with `reg_adr_op` = pointer. On the next cycle `reg_rdata_ip` is loaded into the TX shift register. The first bit is driven at the falling edge ending ACK_DEV or MACK.
- `sda_oe_op` is asserted only for ACK bits in ACK_DEV/ACK_REG/ACK_WR, and for 0 bits in RDATA.

## Timing
- Reset values:
  - outputs: `sda_oe_op`=0, `reg_wr_op`=0, `reg_rd_op`=0, `busy_op`=0, `reg_adr_op`=0, `reg_wdata_op`=0.
  - internal: pointer=0, state IDLE, filtered lines=1.
- Pin to filtered-edge latency: 2+FILT_LEN cycles. Pulses shorter than FILT_LEN cycles are ignored.
- `reg_wr_op` fires 1 cycle after the filtered SCL rise of data bit 0. It is never asserted for a NACKed byte.
- `reg_rd_op` fires 1 cycle after the filtered SCL fall that ends ACK_DEV or a master-ACKed MACK. It is never asserted after a master NACK.
- The minimum SCL low time must exceed FILT_LEN+4 cycles, so read data is ready before the next rise.
- Reset asserted mid-transfer releases SDA asynchronously. After reset the block ignores the bus until a new START.

## Structure
- Package `i2c_pkg`: state enum `i2c_tgt_state_t`; constants `I2C_RW_READ`=1 and `I2C_ACK`=0, shared with the master.
- Sub-module `i2c_pin_filter`: synchroniser plus stability filter, instantiated once per line.

## Test plan
- Write: START, 0x20, 0x05, 0xF6, STOP → ACK on all 3 bytes; one `reg_wr_op` with adr 0x05, data 0xF6; `busy_op` low after STOP.
- Burst wrap: NUM_REGS=16; write reg 0x0F, then 0xAA, 0x55 → strobes at adr 0x0F (0xAA) and adr 0x00 (0x55).
- Read: 0x20, 0x03, repeated START, 0x21; master ACKs then NACKs; model `reg_rdata_ip` = adr^0xA5 → bus carries 0xA6 then 0xA1; `reg_rd_op` fires at 0x03 and 0x04 only.
- Miss/range:
  - Device byte 0x40 → no ACK; `sda_oe_op` stays 0; no strobes.
  - Register byte 0x20 with NUM_REGS=16 → NACK; subsequent data gives no `reg_wr_op`.
- Glitch: 2-cycle SCL high pulse during a data bit with FILT_LEN=3 → no extra bit counted; transfer completes correctly.
- Reset mid-read while driving 0 → `sda_oe_op` drops immediately. The next START, 0x20, 0x00, 0x11 write succeeds with pointer reset.
